// File: rtl/fsm_ctrl_gen.sv
// Dispense controller: IDLE/ARMED/RUN/HOLD/ERROR sequencer driving one-hot motor channels.
// Optional RUN watchdog enabled by defining FSM_CTRL_WATCHDOG_EN.
`timescale 1ns/1ps
module fsm_ctrl_gen #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned WDOG_TICKS = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  input  logic             el,
  input  logic             lp,
  input  logic             done,
  output logic [N_CH-1:0]  motor,
  output logic [2:0]       lcd,
  output logic             led,
  output logic             buzzer,
  output logic             busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  if (N_CH < 1 || N_CH > 16 || (2 ** SEL_W) < N_CH || HOLD_TICKS < 1 || WDOG_TICKS < 2)
  begin : g_param_chk
    $error("fsm_ctrl_gen: illegal parameter combination");
  end

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mode_off;

  assign mode_off = (mode[1] == mode[0]);

`ifdef FSM_CTRL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_TICKS + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
    end
  end

  // Counters read zero outside their own state, so each is cleared on entry.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hold_d  = '0;
`ifdef FSM_CTRL_WATCHDOG_EN
    wd_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mode == 2'b01) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (sel_valid) begin
          if (32'(sel) >= N_CH) begin
            state_d = S_ERROR;
          end else if (el && !lp) begin
            ch_d    = sel;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (done) begin
          state_d = S_HOLD;
`ifdef FSM_CTRL_WATCHDOG_EN
        end else if (wd_q == WD_W'(WDOG_TICKS - 1)) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(HOLD_TICKS - 1)) state_d = S_ARMED;
        else                                   hold_d  = hold_q + HOLD_W'(1);
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Service mode always wins; off only aborts an active sequence, never ERROR.
    if (mode == 2'b10) begin
      state_d = S_IDLE;
    end else if (mode_off && (state_q == S_ARMED || state_q == S_RUN || state_q == S_HOLD)) begin
      state_d = S_IDLE;
    end
  end

  // Outputs follow the state register directly so reset de-energises immediately.
  always_comb begin
    motor  = '0;
    lcd    = 3'b000;
    led    = 1'b0;
    buzzer = 1'b0;
    busy   = 1'b0;
    case (state_q)
      S_ARMED: lcd = 3'b001;
      S_RUN: begin
        busy = 1'b1;
        if (lp) begin
          lcd = 3'b011;
        end else begin
          lcd   = 3'b010;
          motor = N_CH'(1) << ch_q;
        end
      end
      S_HOLD: begin
        lcd    = 3'b100;
        buzzer = 1'b1;
        busy   = 1'b1;
      end
      S_ERROR: begin
        lcd = 3'b111;
        led = 1'b1;
      end
      default: lcd = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_fsm_ctrl_gen.sv
// Scoreboard bench for fsm_ctrl_gen (N_CH=3 so sel=3 is illegal); watchdog leg follows FSM_CTRL_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_fsm_ctrl_gen;
  localparam int unsigned N_CH       = 3;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned HOLD_TICKS = 8;
  localparam int unsigned WDOG_TICKS = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [SEL_W-1:0] sel = '0;
  logic             sel_valid = 1'b0;
  logic             el = 1'b0;
  logic             lp = 1'b0;
  logic             done = 1'b0;
  logic [N_CH-1:0]  motor;
  logic [2:0]       lcd;
  logic             led, buzzer, busy;

  typedef struct packed {
    logic [N_CH-1:0] motor;
    logic [2:0]      lcd;
    logic            led;
    logic            buzzer;
    logic            busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  event  mon_ev;

  always #5 clk = ~clk;

  fsm_ctrl_gen #(
    .N_CH(N_CH), .SEL_W(SEL_W), .HOLD_TICKS(HOLD_TICKS), .WDOG_TICKS(WDOG_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .el(el), .lp(lp), .done(done), .motor(motor), .lcd(lcd), .led(led),
    .buzzer(buzzer), .busy(busy)
  );

  always @(negedge clk) -> mon_ev;

  // Monitor: compares the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(mon_ev);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {motor, lcd, led, buzzer, busy};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got motor=%b lcd=%b led=%b buzzer=%b busy=%b, want motor=%b lcd=%b led=%b buzzer=%b busy=%b",
                   nm, act.motor, act.lcd, act.led, act.buzzer, act.busy,
                   e.motor, e.lcd, e.led, e.buzzer, e.busy);
        end
      end
    end
  end

  task automatic push_exp(string nm, logic [N_CH-1:0] m, logic [2:0] l, logic ld, logic bz, logic bs);
    exp_q.push_back({m, l, ld, bz, bs});
    name_q.push_back(nm);
  endtask

  // One clock edge with the current inputs, then one expectation for the resulting cycle.
  task automatic cyc(string nm, logic [N_CH-1:0] m, logic [2:0] l, logic ld, logic bz, logic bs);
    @(posedge clk);
    #1;
    push_exp(nm, m, l, ld, bz, bs);
    @(negedge clk);
    #1;
  endtask

  task automatic c_idle(string nm);          cyc(nm, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0); endtask
  task automatic c_armed(string nm);         cyc(nm, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0); endtask
  task automatic c_run(string nm, logic [N_CH-1:0] m); cyc(nm, m, 3'b010, 1'b0, 1'b0, 1'b1); endtask
  task automatic c_pause(string nm);         cyc(nm, 3'b000, 3'b011, 1'b0, 1'b0, 1'b1); endtask
  task automatic c_hold(string nm);          cyc(nm, 3'b000, 3'b100, 1'b0, 1'b1, 1'b1); endtask
  task automatic c_err(string nm);           cyc(nm, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, want completion", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, then idle with mode off after release
    c_idle("reset_state");
    reset = 1'b0;
    c_idle("idle_mode_off");

    // Arm and start on channel 2
    mode = 2'b01; sel = 2'd2; sel_valid = 1'b1; el = 1'b1; lp = 1'b0;
    c_armed("arm_after_1_edge");
    c_run("run_ch2", 3'b100);
    sel_valid = 1'b0;

    // Pause for 5 cycles, done while paused, 8-cycle hold ignoring an illegal sel
    lp = 1'b1;
    for (int i = 0; i < 5; i++) c_pause("pause");
    done = 1'b1;
    c_hold("hold_entry_done_over_lp");
    done = 1'b0; lp = 1'b0; sel = 2'd3; sel_valid = 1'b1;
    for (int i = 1; i < int'(HOLD_TICKS); i++) c_hold("hold_cycle");
    c_armed("hold_exit_armed");
    sel_valid = 1'b0;

    // Illegal channel -> ERROR, sticky until service mode
    sel = 2'd3; sel_valid = 1'b1;
    c_err("illegal_sel_error");
    sel_valid = 1'b0;
    c_err("error_mode01_a");
    c_err("error_mode01_b");
    mode = 2'b00; c_err("error_mode00");
    mode = 2'b11; c_err("error_mode11");
    mode = 2'b10; c_idle("service_to_idle");
    mode = 2'b01; c_armed("rearm");
    mode = 2'b11; c_idle("armed_mode11_idle");
    mode = 2'b01; c_armed("rearm2");

    // Legal sel gated by el and lp
    sel = 2'd1; sel_valid = 1'b1; el = 1'b0;
    c_armed("el0_ignored");
    el = 1'b1; lp = 1'b1;
    c_armed("lp1_ignored");
    lp = 1'b0;
    c_run("run_ch1", 3'b010);
    sel_valid = 1'b0;

    // Asynchronous reset between edges during RUN
    #1 reset = 1'b1;
    #1 push_exp("async_reset_immediate", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    -> mon_ev;
    #1;
    c_idle("reset_held_over_edge");
    reset = 1'b0;
    c_armed("first_edge_mode01");

    // RUN on channel 0 with done never asserted
    sel = 2'd0; sel_valid = 1'b1;
    c_run("run_ch0", 3'b001);
    sel_valid = 1'b0;
`ifdef FSM_CTRL_WATCHDOG_EN
    for (int i = 2; i <= int'(WDOG_TICKS); i++) begin
      lp = (i >= 5 && i <= 9);
      if (lp) c_pause("wd_run_paused");
      else    c_run("wd_run", 3'b001);
    end
    lp = 1'b0;
    c_err("watchdog_error");
    mode = 2'b10; c_idle("wd_service_idle");
`else
    for (int i = 2; i <= 100; i++) begin
      lp = (i >= 5 && i <= 9);
      if (lp) c_pause("no_wd_run_paused");
      else    c_run("no_wd_run", 3'b001);
    end
    lp = 1'b0;
    mode = 2'b00; c_idle("run_mode_off_idle");
`endif

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
